branch_redirect_ctrl: RTL and testbench

Sequences control-flow redirects for the pipelined core. It consumes the 3-bit PC source code produced by the branch condition generator in EX and latches the selected target. It drives a redirect handshake to the fetch stage, flushes wrong-path IF/ID contents for the exact number of cycles required, and keeps a saturating count of accepted redirects for performance monitoring.

---
 rtl/branch_redirect_ctrl.sv | 61 ++++++
 tb/tb_branch_redirect_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: latches EX redirect targets, handshakes them to fetch, flushes IF/ID and counts redirects
module branch_redirect_ctrl #(
  parameter int XLEN = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             stall,
  input  logic [2:0]       ex_pc_source,
  input  logic [XLEN-1:0]  jalr_tgt,
  input  logic [XLEN-1:0]  branch_tgt,
  input  logic [XLEN-1:0]  jal_tgt,
  input  logic             imem_ready,
  input  logic             cnt_clr,
  output logic             redirect,
  output logic [XLEN-1:0]  next_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             busy,
  output logic             illegal_src,
  output logic [CNT_W-1:0] redirect_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, PEND = 2'd1, SQUASH = 2'd2} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] tgt_n;
  logic [CNT_W-1:0] cnt_n;
  logic eval, detect, hs;
  always_comb begin
    eval = state == RUN && ex_valid && !stall;
    detect = eval && ex_pc_source inside {3'b001, 3'b010, 3'b011};
    hs = state == PEND && imem_ready;
    state_n = detect ? PEND : hs ? SQUASH : (state == PEND) ? PEND : RUN;
    tgt_n = !detect ? next_pc :
            ex_pc_source == 3'b001 ? jalr_tgt :
            ex_pc_source == 3'b010 ? branch_tgt : jal_tgt;
    cnt_n = cnt_clr ? '0 : (hs && !(&redirect_cnt)) ? redirect_cnt + CNT_W'(1) : redirect_cnt;
  end
  // outputs are registered from the next state so nothing is decoded after a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      next_pc <= '0;
      redirect <= 1'b0;
      flush_if <= 1'b0;
      flush_id <= 1'b0;
      busy <= 1'b0;
      illegal_src <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state <= state_n;
      next_pc <= tgt_n;
      redirect <= state_n == PEND;
      flush_if <= state_n != RUN;
      flush_id <= state_n == PEND;
      busy <= state_n != RUN;
      illegal_src <= illegal_src | (eval && ex_pc_source[2]);
      redirect_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed and random stimulus checked against a transaction-level redirect model
module tb_branch_redirect_ctrl;
  localparam int XLEN = 32;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rst_n = 0, ex_valid = 0, stall = 0, imem_ready = 0, cnt_clr = 0;
  logic [2:0] src = 0;
  logic [XLEN-1:0] jalr_tgt = 0, branch_tgt = 0, jal_tgt = 0;
  logic redirect, flush_if, flush_id, busy, illegal_src;
  logic [XLEN-1:0] next_pc;
  logic [CW-1:0] redirect_cnt;
  int checks = 0, failures = 0;
  bit m_wait, m_sq, m_ill;
  logic [XLEN-1:0] m_tgt;
  int m_cnt;

  branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall(stall), .ex_pc_source(src),
    .jalr_tgt(jalr_tgt), .branch_tgt(branch_tgt), .jal_tgt(jal_tgt),
    .imem_ready(imem_ready), .cnt_clr(cnt_clr), .redirect(redirect), .next_pc(next_pc),
    .flush_if(flush_if), .flush_id(flush_id), .busy(busy), .illegal_src(illegal_src),
    .redirect_cnt(redirect_cnt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_sq = 0; m_ill = 0; m_tgt = 0; m_cnt = 0;
  endtask

  // one redirect is a transaction: wait for fetch, then one squash cycle
  task automatic model_edge();
    if (m_wait) begin
      if (imem_ready) begin
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        m_wait = 0;
        m_sq = 1;
      end
    end else if (m_sq) m_sq = 0;
    else if (ex_valid && !stall) begin
      case (src)
        3'd1: begin m_wait = 1; m_tgt = jalr_tgt; end
        3'd2: begin m_wait = 1; m_tgt = branch_tgt; end
        3'd3: begin m_wait = 1; m_tgt = jal_tgt; end
        3'd0: ;
        default: m_ill = 1;
      endcase
    end
    if (cnt_clr) m_cnt = 0;
  endtask

  task automatic compare_all();
    check("redirect", 32'(redirect), 32'(m_wait));
    check("flush_if", 32'(flush_if), 32'(m_wait | m_sq));
    check("flush_id", 32'(flush_id), 32'(m_wait));
    check("busy", 32'(busy), 32'(m_wait | m_sq));
    check("next_pc", next_pc, m_tgt);
    check("illegal_src", 32'(illegal_src), 32'(m_ill));
    check("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 0;
    #1 model_reset();
    check("rst_redirect", 32'(redirect), 0);
    check("rst_flush_if", 32'(flush_if), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_next_pc", next_pc, 0);
    check("rst_cnt", 32'(redirect_cnt), 0);
    check("rst_illegal", 32'(illegal_src), 0);
    #1 rst_n = 1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    rst_n = 1;
    step();
    check("idle_busy", 32'(busy), 0);
    // taken branch with immediate acceptance
    ex_valid = 1; src = 3'b010; branch_tgt = 32'h100; imem_ready = 1;
    step();
    ex_valid = 0; src = 0;
    check("br_redirect", 32'(redirect), 1);
    check("br_next_pc", next_pc, 32'h100);
    check("br_flush_id", 32'(flush_id), 1);
    step();
    check("br_squash_if", 32'(flush_if), 1);
    check("br_squash_id", 32'(flush_id), 0);
    check("br_cnt_in_squash", 32'(redirect_cnt), 1);
    step();
    check("br_idle", 32'(busy), 0);
    // JAL under backpressure; a branch shown in EX during PEND must be ignored
    ex_valid = 1; src = 3'b011; jal_tgt = 32'h200; imem_ready = 0;
    step();
    src = 3'b010; branch_tgt = 32'h300;
    repeat (3) begin
      step();
      check("bp_hold_pc", next_pc, 32'h200);
      check("bp_hold_req", 32'(redirect), 1);
    end
    imem_ready = 1; ex_valid = 0; src = 0;
    step();
    check("bp_cnt_once", 32'(redirect_cnt), 2);
    step();
    // JALR held by a stall
    ex_valid = 1; src = 3'b001; jalr_tgt = 32'h440; stall = 1;
    repeat (2) begin
      step();
      check("stall_no_redirect", 32'(redirect), 0);
    end
    stall = 0;
    step();
    ex_valid = 0; src = 0;
    check("stall_release", next_pc, 32'h440);
    repeat (2) step();
    // none and illegal codes
    ex_valid = 1; src = 3'b000;
    repeat (2) step();
    src = 3'b101;
    step();
    check("illegal_set", 32'(illegal_src), 1);
    src = 0; ex_valid = 0;
    repeat (2) step();
    check("illegal_sticky", 32'(illegal_src), 1);
    check("illegal_no_redirect", 32'(redirect), 0);
    // drive the counter past saturation
    imem_ready = 1;
    for (int i = 0; i < CMAX + 3; i++) begin
      ex_valid = 1; src = 3'b011; jal_tgt = 32'(i * 4);
      step();
      ex_valid = 0;
      repeat (2) step();
    end
    check("cnt_saturated", 32'(redirect_cnt), CMAX);
    // clear coinciding with a handshake
    ex_valid = 1; src = 3'b010;
    step();
    ex_valid = 0; cnt_clr = 1;
    step();
    cnt_clr = 0;
    check("clr_beats_inc", 32'(redirect_cnt), 0);
    step();
    // reset asserted while a redirect is pending
    imem_ready = 0; ex_valid = 1; src = 3'b001; jalr_tgt = 32'hdead_beef;
    step();
    async_reset();
    ex_valid = 0; src = 0;
    step();
    check("post_rst_busy", 32'(busy), 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      ex_valid = 1'($urandom_range(0, 3) != 0);
      stall = 1'($urandom_range(0, 3) == 0);
      src = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      jalr_tgt = $urandom; branch_tgt = $urandom; jal_tgt = $urandom;
      imem_ready = 1'($urandom_range(0, 2) != 0);
      cnt_clr = 1'($urandom_range(0, 60) == 0);
      step();
      if ($urandom_range(0, 400) == 0) async_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
